time_set_ctrl: RTL and testbench

//  Time-setting controller for the digital clock. Consumes the debounced, active-low

---
 rtl/clock_pkg.sv | 27 ++
 rtl/key_repeat.sv | 70 +++++++
 rtl/time_set_ctrl.sv | 172 +++++++++++++++++
 tb/tb_time_set_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types and constants for the digital clock time-setting path.
package clock_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2,
        SET_SEC  = 2'd3
    } mode_e;

    localparam int HOUR_MAX = 23;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_W   = 5;
    localparam int MIN_W    = 6;

    // One wrap-around step of a time field; up=1 increments, up=0 decrements.
    // Fields are never carried into their neighbours.
    function automatic logic [MIN_W-1:0] wrap_step(input logic [MIN_W-1:0] v,
                                                   input logic [MIN_W-1:0] max_v,
                                                   input logic             up);
        if (up)
            return (v >= max_v) ? '0 : v + 1'b1;
        else
            return (v == '0) ? max_v : v - 1'b1;
    endfunction

endpackage

// File: rtl/key_repeat.sv
// Press detection plus hold-to-repeat for one debounced, active-low key.
// step fires on the press, again after HOLD_DLY cycles of continuous low,
// then every RPT_PERIOD cycles. Dropping enable disarms the key, so a hold
// that spans a mode change stays silent until it is released and re-pressed.
module key_repeat #(
    parameter int HOLD_DLY   = 50000,
    parameter int RPT_PERIOD = 10000
) (
    input  logic clk100khz,
    input  logic rst_n,
    input  logic key_n,
    input  logic enable,
    output logic step
);

    localparam int CNT_MAX = (HOLD_DLY > RPT_PERIOD) ? HOLD_DLY : RPT_PERIOD;
    localparam int CW      = $clog2(CNT_MAX + 1);

    logic          key_q;    // current sample
    logic          hist;     // previous sample
    logic          armed;    // press was accepted while enabled
    logic          rpt;      // past the initial hold delay
    logic [CW-1:0] cnt;
    logic          press;
    logic          held;
    logic          hit;

    assign press = hist & ~key_q;
    // Repeat only while both the sampled and the live key are still low,
    // so a release arriving this cycle cancels a repeat due on the same edge.
    assign held  = armed & ~key_q & ~key_n;
    assign hit   = rpt ? (cnt == CW'(RPT_PERIOD)) : (cnt == CW'(HOLD_DLY));
    assign step  = enable & (press | (held & hit));

    // Key sample and history registers.
    always_ff @(posedge clk100khz or negedge rst_n) begin
        if (!rst_n) begin
            key_q <= 1'b1;
            hist  <= 1'b1;
        end else begin
            key_q <= key_n;
            hist  <= key_q;
        end
    end

    // Hold/repeat timer: starts on an accepted press, cleared on release or disable.
    always_ff @(posedge clk100khz or negedge rst_n) begin
        if (!rst_n) begin
            armed <= 1'b0;
            rpt   <= 1'b0;
            cnt   <= '0;
        end else if (!enable || key_q) begin
            armed <= 1'b0;
            rpt   <= 1'b0;
            cnt   <= '0;
        end else if (press) begin
            armed <= 1'b1;
            rpt   <= 1'b0;
            cnt   <= CW'(1);
        end else if (held) begin
            if (hit) begin
                rpt <= 1'b1;
                cnt <= CW'(1);
            end else if (cnt < CW'(CNT_MAX)) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// Time-setting controller: walks RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN,
// edits a shadow copy of the time and commits it with a one-cycle load strobe.
module time_set_ctrl
    import clock_pkg::*;
#(
    parameter int HOLD_DLY   = 50000,
    parameter int RPT_PERIOD = 10000,
    parameter int BLINK_HALF = 50000,
    parameter int TIMEOUT    = 3000000
) (
    input  logic       clk100khz,
    input  logic       rst_n,
    input  logic       mode_set,
    input  logic       inc,
    input  logic       dec,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    output logic [4:0] edit_hour,
    output logic [5:0] edit_min,
    output logic [5:0] edit_sec,
    output logic [1:0] edit_field,
    output logic       load,
    output logic       running,
    output logic       blink
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int BW = $clog2(BLINK_HALF + 1);

    mode_e         state;
    mode_e         state_nxt;
    logic          load_nxt;
    logic          mode_q;
    logic          mode_hist;
    logic          mode_press;
    logic          in_set;
    logic          key_en;
    logic          inc_step;
    logic          dec_step;
    logic          do_inc;
    logic          do_dec;
    logic          do_step;
    logic          timeout;
    logic [TW-1:0] idle_cnt;
    logic [BW-1:0] blink_cnt;

    assign in_set     = (state != RUN);
    assign mode_press = mode_hist & ~mode_q;
    // A mode press in the same cycle wins: the step keys are disabled for it.
    assign key_en     = in_set & ~mode_press;
    assign do_inc     = inc_step & ~dec_step;
    assign do_dec     = dec_step & ~inc_step;
    assign do_step    = do_inc | do_dec;
    assign timeout    = (idle_cnt == TW'(TIMEOUT));
    assign edit_field = state;

    key_repeat #(.HOLD_DLY(HOLD_DLY), .RPT_PERIOD(RPT_PERIOD)) u_inc_key (
        .clk100khz (clk100khz),
        .rst_n     (rst_n),
        .key_n     (inc),
        .enable    (key_en),
        .step      (inc_step)
    );

    key_repeat #(.HOLD_DLY(HOLD_DLY), .RPT_PERIOD(RPT_PERIOD)) u_dec_key (
        .clk100khz (clk100khz),
        .rst_n     (rst_n),
        .key_n     (dec),
        .enable    (key_en),
        .step      (dec_step)
    );

    // Mode button history: edge detect only, no repeat.
    always_ff @(posedge clk100khz or negedge rst_n) begin
        if (!rst_n) begin
            mode_q    <= 1'b1;
            mode_hist <= 1'b1;
        end else begin
            mode_q    <= mode_set;
            mode_hist <= mode_q;
        end
    end

    // State register with registered load/running so both line up with the state.
    always_ff @(posedge clk100khz or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RUN;
            load    <= 1'b0;
            running <= 1'b1;
        end else begin
            state   <= state_nxt;
            load    <= load_nxt;
            running <= (state_nxt == RUN);
        end
    end

    // Next-state: mode advances the field, timeout abandons the edit without a load.
    always_comb begin
        state_nxt = state;
        load_nxt  = 1'b0;
        case (state)
            RUN:      if (mode_press) state_nxt = SET_HOUR;
            SET_HOUR: if (mode_press) state_nxt = SET_MIN;
                      else if (timeout) state_nxt = RUN;
            SET_MIN:  if (mode_press) state_nxt = SET_SEC;
                      else if (timeout) state_nxt = RUN;
            SET_SEC:  if (mode_press) begin
                          state_nxt = RUN;
                          load_nxt  = 1'b1;
                      end else if (timeout) begin
                          state_nxt = RUN;
                      end
            default:  state_nxt = RUN;
        endcase
    end

    // Shadow time: captured on entry to SET_HOUR, then stepped one field at a time.
    always_ff @(posedge clk100khz or negedge rst_n) begin
        if (!rst_n) begin
            edit_hour <= '0;
            edit_min  <= '0;
            edit_sec  <= '0;
        end else if (state == RUN) begin
            if (mode_press) begin
                edit_hour <= cur_hour;
                edit_min  <= cur_min;
                edit_sec  <= cur_sec;
            end
        end else if (do_step) begin
            case (state)
                SET_HOUR: edit_hour <= HOUR_W'(wrap_step(MIN_W'(edit_hour), MIN_W'(HOUR_MAX), do_inc));
                SET_MIN:  edit_min  <= wrap_step(edit_min, MIN_W'(MIN_MAX), do_inc);
                SET_SEC:  edit_sec  <= wrap_step(edit_sec, MIN_W'(MIN_MAX), do_inc);
                default:  ;
            endcase
        end
    end

    // Idle timer: counts quiet cycles in a set state, saturating at TIMEOUT.
    always_ff @(posedge clk100khz or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (!in_set || state_nxt == RUN) begin
            idle_cnt <= '0;
        end else if (mode_press || inc_step || dec_step) begin
            idle_cnt <= '0;
        end else if (!timeout) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    // Blink: off in RUN; forced visible on field entry or any edit, then toggles.
    always_ff @(posedge clk100khz or negedge rst_n) begin
        if (!rst_n) begin
            blink     <= 1'b0;
            blink_cnt <= '0;
        end else if (state_nxt == RUN) begin
            blink     <= 1'b0;
            blink_cnt <= '0;
        end else if (mode_press || do_step) begin
            blink     <= 1'b1;
            blink_cnt <= '0;
        end else if (blink_cnt == BW'(BLINK_HALF - 1)) begin
            blink     <= ~blink;
            blink_cnt <= '0;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl with shortened timing parameters.
module tb_time_set_ctrl;

    logic       clk100khz = 1'b0;
    logic       rst_n     = 1'b0;
    logic       mode_set  = 1'b1;
    logic       inc       = 1'b1;
    logic       dec       = 1'b1;
    logic [4:0] cur_hour  = 5'd12;
    logic [5:0] cur_min   = 6'd34;
    logic [5:0] cur_sec   = 6'd56;
    logic [4:0] edit_hour;
    logic [5:0] edit_min;
    logic [5:0] edit_sec;
    logic [1:0] edit_field;
    logic       load;
    logic       running;
    logic       blink;

    int n_checks = 0;
    int n_fail   = 0;
    int load_cnt = 0;
    int load_bad = 0;
    int lc0;

    time_set_ctrl #(
        .HOLD_DLY   (20),
        .RPT_PERIOD (5),
        .BLINK_HALF (8),
        .TIMEOUT    (200)
    ) dut (
        .clk100khz  (clk100khz),
        .rst_n      (rst_n),
        .mode_set   (mode_set),
        .inc        (inc),
        .dec        (dec),
        .cur_hour   (cur_hour),
        .cur_min    (cur_min),
        .cur_sec    (cur_sec),
        .edit_hour  (edit_hour),
        .edit_min   (edit_min),
        .edit_sec   (edit_sec),
        .edit_field (edit_field),
        .load       (load),
        .running    (running),
        .blink      (blink)
    );

    always #5 clk100khz = ~clk100khz;

    // Count load strobes and note any that come without running.
    always @(negedge clk100khz) begin
        if (load === 1'b1) begin
            load_cnt++;
            if (running !== 1'b1) load_bad++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk100khz);
            #1;
        end
    endtask

    task automatic pulse_mode();
        mode_set = 1'b0; cyc(1); mode_set = 1'b1; cyc(1);
    endtask

    task automatic pulse_inc();
        inc = 1'b0; cyc(1); inc = 1'b1; cyc(1);
    endtask

    task automatic pulse_dec();
        dec = 1'b0; cyc(1); dec = 1'b1; cyc(1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc(3);
        n_checks++; if (edit_field !== 2'd0) begin n_fail++; $display("FAIL reset_field: got %0d exp 0", edit_field); end
        n_checks++; if ({edit_hour, edit_min, edit_sec} !== 17'd0) begin n_fail++; $display("FAIL reset_edit: got %0d:%0d:%0d exp 0:0:0", edit_hour, edit_min, edit_sec); end
        n_checks++; if (load !== 1'b0) begin n_fail++; $display("FAIL reset_load: got %b exp 0", load); end
        n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL reset_running: got %b exp 1", running); end
        n_checks++; if (blink !== 1'b0) begin n_fail++; $display("FAIL reset_blink: got %b exp 0", blink); end
        rst_n = 1'b1;
        cyc(2);
    endtask

    task automatic test_enter_set();
        pulse_mode();
        n_checks++; if (edit_field !== 2'd1) begin n_fail++; $display("FAIL enter_field: got %0d exp 1", edit_field); end
        n_checks++; if ({edit_hour, edit_min, edit_sec} !== {5'd12, 6'd34, 6'd56}) begin n_fail++; $display("FAIL enter_edit: got %0d:%0d:%0d exp 12:34:56", edit_hour, edit_min, edit_sec); end
        n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL enter_running: got %b exp 0", running); end
        n_checks++; if (blink !== 1'b1) begin n_fail++; $display("FAIL enter_blink: got %b exp 1", blink); end
        n_checks++; if (load !== 1'b0) begin n_fail++; $display("FAIL enter_load: got %b exp 0", load); end
        cyc(7);
        n_checks++; if (blink !== 1'b1) begin n_fail++; $display("FAIL blink_hold: got %b exp 1", blink); end
        cyc(1);
        n_checks++; if (blink !== 1'b0) begin n_fail++; $display("FAIL blink_toggle: got %b exp 0", blink); end
    endtask

    task automatic test_wrap();
        pulse_dec();
        n_checks++; if (blink !== 1'b1) begin n_fail++; $display("FAIL step_blink: got %b exp 1", blink); end
        n_checks++; if (edit_hour !== 5'd11) begin n_fail++; $display("FAIL hour_dec: got %0d exp 11", edit_hour); end
        repeat (11) pulse_dec();
        n_checks++; if (edit_hour !== 5'd0) begin n_fail++; $display("FAIL hour_zero: got %0d exp 0", edit_hour); end
        pulse_dec();
        n_checks++; if (edit_hour !== 5'd23) begin n_fail++; $display("FAIL hour_dec_wrap: got %0d exp 23", edit_hour); end
        pulse_inc();
        n_checks++; if (edit_hour !== 5'd0) begin n_fail++; $display("FAIL hour_inc_wrap: got %0d exp 0", edit_hour); end
        pulse_dec();
        n_checks++; if (edit_hour !== 5'd23) begin n_fail++; $display("FAIL hour_dec_wrap2: got %0d exp 23", edit_hour); end
        pulse_mode();
        n_checks++; if (edit_field !== 2'd2) begin n_fail++; $display("FAIL to_min_field: got %0d exp 2", edit_field); end
        repeat (34) pulse_dec();
        n_checks++; if (edit_min !== 6'd0) begin n_fail++; $display("FAIL min_zero: got %0d exp 0", edit_min); end
        pulse_dec();
        n_checks++; if (edit_min !== 6'd59) begin n_fail++; $display("FAIL min_dec_wrap: got %0d exp 59", edit_min); end
        n_checks++; if (edit_hour !== 5'd23) begin n_fail++; $display("FAIL min_hour_kept: got %0d exp 23", edit_hour); end
        pulse_inc();
        n_checks++; if (edit_min !== 6'd0) begin n_fail++; $display("FAIL min_inc_wrap: got %0d exp 0", edit_min); end
        n_checks++; if (edit_sec !== 6'd56) begin n_fail++; $display("FAIL min_sec_kept: got %0d exp 56", edit_sec); end
    endtask

    task automatic test_hold();
        repeat (10) pulse_inc();
        n_checks++; if (edit_min !== 6'd10) begin n_fail++; $display("FAIL hold_start: got %0d exp 10", edit_min); end
        inc = 1'b0;
        cyc(21);
        n_checks++; if (edit_min !== 6'd11) begin n_fail++; $display("FAIL hold_before_dly: got %0d exp 11", edit_min); end
        cyc(1);
        n_checks++; if (edit_min !== 6'd12) begin n_fail++; $display("FAIL hold_first_rpt: got %0d exp 12", edit_min); end
        cyc(24);
        inc = 1'b1;
        cyc(2);
        n_checks++; if (edit_min !== 6'd16) begin n_fail++; $display("FAIL hold_final: got %0d exp 16", edit_min); end
        n_checks++; if (edit_hour !== 5'd23) begin n_fail++; $display("FAIL hold_hour_kept: got %0d exp 23", edit_hour); end
    endtask

    task automatic test_back_to_back();
        inc = 1'b0; dec = 1'b0; cyc(1); inc = 1'b1; dec = 1'b1; cyc(1);
        n_checks++; if (edit_min !== 6'd16) begin n_fail++; $display("FAIL incdec_same: got %0d exp 16", edit_min); end
        mode_set = 1'b0; inc = 1'b0; cyc(1); mode_set = 1'b1; inc = 1'b1; cyc(1);
        n_checks++; if (edit_field !== 2'd3) begin n_fail++; $display("FAIL modeinc_field: got %0d exp 3", edit_field); end
        n_checks++; if ({edit_min, edit_sec} !== {6'd16, 6'd56}) begin n_fail++; $display("FAIL modeinc_value: got %0d:%0d exp 16:56", edit_min, edit_sec); end
    endtask

    task automatic test_timeout();
        lc0 = load_cnt;
        cyc(200);
        n_checks++; if (edit_field !== 2'd3) begin n_fail++; $display("FAIL timeout_early: got %0d exp 3", edit_field); end
        cyc(1);
        n_checks++; if (edit_field !== 2'd0) begin n_fail++; $display("FAIL timeout_field: got %0d exp 0", edit_field); end
        n_checks++; if (running !== 1'b1 || blink !== 1'b0) begin n_fail++; $display("FAIL timeout_run_blink: got %b%b exp 10", running, blink); end
        cyc(2);
        n_checks++; if (load_cnt !== lc0) begin n_fail++; $display("FAIL timeout_noload: got %0d loads exp 0", load_cnt - lc0); end
        n_checks++; if (edit_min !== 6'd16) begin n_fail++; $display("FAIL timeout_retain: got %0d exp 16", edit_min); end
    endtask

    task automatic test_full_cycle();
        cur_hour = 5'd7; cur_min = 6'd8; cur_sec = 6'd9;
        pulse_mode();
        n_checks++; if ({edit_hour, edit_min, edit_sec} !== {5'd7, 6'd8, 6'd9}) begin n_fail++; $display("FAIL cycle_capture: got %0d:%0d:%0d exp 7:8:9", edit_hour, edit_min, edit_sec); end
        pulse_inc();
        pulse_mode();
        pulse_dec();
        pulse_mode();
        pulse_inc();
        n_checks++; if (running !== 1'b0 || load !== 1'b0) begin n_fail++; $display("FAIL cycle_pre: got running %b load %b exp 0 0", running, load); end
        lc0 = load_cnt;
        pulse_mode();
        n_checks++; if (load !== 1'b1) begin n_fail++; $display("FAIL cycle_load: got %b exp 1", load); end
        n_checks++; if (running !== 1'b1 || edit_field !== 2'd0) begin n_fail++; $display("FAIL cycle_run: got running %b field %0d exp 1 0", running, edit_field); end
        n_checks++; if ({edit_hour, edit_min, edit_sec} !== {5'd8, 6'd7, 6'd10}) begin n_fail++; $display("FAIL cycle_commit: got %0d:%0d:%0d exp 8:7:10", edit_hour, edit_min, edit_sec); end
        cyc(1);
        n_checks++; if (load !== 1'b0) begin n_fail++; $display("FAIL cycle_load_end: got %b exp 0", load); end
        n_checks++; if ({edit_hour, edit_min, edit_sec} !== {5'd8, 6'd7, 6'd10}) begin n_fail++; $display("FAIL cycle_stable: got %0d:%0d:%0d exp 8:7:10", edit_hour, edit_min, edit_sec); end
        cyc(3);
        n_checks++; if (load_cnt - lc0 !== 1) begin n_fail++; $display("FAIL cycle_one_load: got %0d exp 1", load_cnt - lc0); end
        n_checks++; if (load_bad !== 0) begin n_fail++; $display("FAIL load_running: got %0d exp 0", load_bad); end
    endtask

    task automatic test_reset_mid();
        pulse_mode();
        pulse_mode();
        lc0 = load_cnt;
        inc = 1'b0;
        cyc(25);
        rst_n = 1'b0;
        #1;
        n_checks++; if (edit_field !== 2'd0 || running !== 1'b1) begin n_fail++; $display("FAIL rstmid_state: got field %0d running %b exp 0 1", edit_field, running); end
        n_checks++; if ({edit_hour, edit_min, edit_sec} !== 17'd0) begin n_fail++; $display("FAIL rstmid_edit: got %0d:%0d:%0d exp 0:0:0", edit_hour, edit_min, edit_sec); end
        n_checks++; if (load !== 1'b0 || blink !== 1'b0) begin n_fail++; $display("FAIL rstmid_load_blink: got %b%b exp 00", load, blink); end
        inc = 1'b1;
        cyc(2);
        rst_n = 1'b1;
        cyc(5);
        n_checks++; if (load_cnt !== lc0) begin n_fail++; $display("FAIL rstmid_noload: got %0d loads exp 0", load_cnt - lc0); end
        n_checks++; if (edit_field !== 2'd0) begin n_fail++; $display("FAIL rstmid_after: got %0d exp 0", edit_field); end
    endtask

    initial begin
        test_reset();
        test_enter_set();
        test_wrap();
        test_hold();
        test_back_to_back();
        test_timeout();
        test_full_cycle();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
